// File: rtl/game_sequencer_pkg.sv
// Shared types and constants for the baseball game sequencer.
// Holds the FSM states, latched error codes, game geometry and scorer action codes.
package game_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_STALL   = 3'd1;
  localparam logic [2:0] ERR_OUTS    = 3'd2;
  localparam logic [2:0] ERR_LAST    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_OVERLAP = 3'd5;

  localparam logic [1:0] OUTS_PER_HALF = 2'd3;
  localparam logic [1:0] LAST_INNING   = 2'd3;
  localparam logic [1:0] FIRST_INNING  = 2'd1;

  // Action codes are opaque to the sequencer; they only pass through to the scorer.
  localparam logic [2:0] ACT_OUT    = 3'd0;
  localparam logic [2:0] ACT_SINGLE = 3'd1;
  localparam logic [2:0] ACT_DOUBLE = 3'd2;
  localparam logic [2:0] ACT_TRIPLE = 3'd3;
  localparam logic [2:0] ACT_HOMER  = 3'd4;
  localparam logic [2:0] ACT_WALK   = 3'd5;
  localparam logic [2:0] ACT_SAC    = 3'd6;
  localparam logic [2:0] ACT_NOP    = 3'd7;

  function automatic logic [2:0] outs_sum(input logic [1:0] outs, input logic [1:0] add);
    return {1'b0, outs} + {1'b0, add};
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Play feed, scorer and result-consumer signals of the game sequencer.
// The master modport is the sequencer's view; slave is the surrounding environment.
interface game_sequencer_if;
  logic       play_valid;
  logic       play_ready;
  logic [2:0] play_action;
  logic [1:0] play_outs;
  logic       play_last;
  logic       sc_in_valid;
  logic [1:0] sc_inning;
  logic       sc_half;
  logic [2:0] sc_action;
  logic       sc_out_valid;
  logic [7:0] sc_score_a;
  logic [7:0] sc_score_b;
  logic [1:0] sc_result;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_score_a;
  logic [7:0] res_score_b;
  logic [1:0] res_result;

  modport master (
    input  play_valid, play_action, play_outs, play_last,
    input  sc_out_valid, sc_score_a, sc_score_b, sc_result, res_ready,
    output play_ready, sc_in_valid, sc_inning, sc_half, sc_action,
    output res_valid, res_score_a, res_score_b, res_result
  );

  modport slave (
    output play_valid, play_action, play_outs, play_last,
    output sc_out_valid, sc_score_a, sc_score_b, sc_result, res_ready,
    input  play_ready, sc_in_valid, sc_inning, sc_half, sc_action,
    input  res_valid, res_score_a, res_score_b, res_result
  );
endinterface

// File: rtl/game_sequencer_half_inning_tracker.sv
// Outs/half/inning bookkeeping for one game, plus legality flags for the play being offered.
// A load presents the game-start position (inning 1 top, no outs) combinationally.
module half_inning_tracker
  import game_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_advance,
  input  logic [1:0] i_play_outs,
  output logic [1:0] o_inning,
  output logic       o_half,
  output logic       o_half_end,
  output logic       o_outs_overflow,
  output logic       o_last_legal,
  output logic       o_last_required
);

  logic [1:0] r_inning;
  logic       r_half;
  logic [1:0] r_outs;
  logic [1:0] w_outs;
  logic [2:0] w_sum;

  assign o_inning = i_load ? FIRST_INNING : r_inning;
  assign o_half   = i_load ? 1'b0 : r_half;
  assign w_outs   = i_load ? 2'd0 : r_outs;
  assign w_sum    = outs_sum(w_outs, i_play_outs);

  assign o_outs_overflow = (i_play_outs == OUTS_PER_HALF) || (w_sum > {1'b0, OUTS_PER_HALF});
  assign o_half_end      = (w_sum == {1'b0, OUTS_PER_HALF});
  // A game may end anywhere in the bottom of the last inning, or on the top's third out.
  assign o_last_legal    = (o_inning == LAST_INNING) && (o_half || o_half_end);
  assign o_last_required = (o_inning == LAST_INNING) && o_half && o_half_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inning <= 2'd0;
      r_half   <= 1'b0;
      r_outs   <= 2'd0;
    end else if (i_advance) begin
      if (o_half_end) begin
        r_outs <= 2'd0;
        if (!o_half) begin
          r_inning <= o_inning;
          r_half   <= 1'b1;
        end else begin
          r_inning <= o_inning + 2'd1;
          r_half   <= 1'b0;
        end
      end else begin
        r_inning <= o_inning;
        r_half   <= o_half;
        r_outs   <= w_sum[1:0];
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Sequences one game of plays into the scorer, waits for its result pulse and holds it
// for the consumer; protocol violations latch a sticky error until reset.
module game_sequencer
  import game_seq_pkg::*;
#(
  parameter int TIMEOUT = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  game_sequencer_if.master        bus,
  output logic [7:0]              game_cnt,
  output logic                    err,
  output logic [2:0]              err_code
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t     r_state, r_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic       r_sc_in_valid;
  logic [1:0] r_sc_inning;
  logic       r_sc_half;
  logic [2:0] r_sc_action;
  logic [7:0] r_res_score_a;
  logic [7:0] r_res_score_b;
  logic [1:0] r_res_result;
  logic [7:0] r_game_cnt;
  logic       r_err;
  logic [2:0] r_err_code;

  logic       w_play_ready;
  logic       w_load;
  logic       w_emit;
  logic       w_capture;
  logic       w_game_done;
  logic [2:0] w_err_cause;
  logic [2:0] w_play_err;
  logic [1:0] w_inning;
  logic       w_half;
  logic       w_half_end;
  logic       w_outs_overflow;
  logic       w_last_legal;
  logic       w_last_required;

  assign w_play_ready = (r_state == S_IDLE) || (r_state == S_PLAY);
  assign w_load       = (r_state == S_IDLE) && bus.play_valid;
  assign w_cnt_inc    = r_cnt + CW'(1);

  half_inning_tracker u_tracker (
    .clk             (clk),
    .rst             (rst),
    .i_load          (w_load),
    .i_advance       (w_emit),
    .i_play_outs     (bus.play_outs),
    .o_inning        (w_inning),
    .o_half          (w_half),
    .o_half_end      (w_half_end),
    .o_outs_overflow (w_outs_overflow),
    .o_last_legal    (w_last_legal),
    .o_last_required (w_last_required)
  );

  assign w_play_err = w_outs_overflow ? ERR_OUTS :
                      ((bus.play_last && !w_last_legal) ||
                       (w_last_required && !bus.play_last)) ? ERR_LAST : ERR_NONE;

  always_comb begin
    r_state_next = r_state;
    w_emit       = 1'b0;
    w_capture    = 1'b0;
    w_game_done  = 1'b0;
    w_err_cause  = ERR_NONE;
    case (r_state)
      S_IDLE, S_PLAY: begin
        if (!bus.play_valid) begin
          if (r_state == S_PLAY) w_err_cause = ERR_STALL;
        end else if (w_play_err != ERR_NONE) begin
          w_err_cause = w_play_err;
        end else begin
          w_emit       = 1'b1;
          r_state_next = bus.play_last ? S_WAIT : S_PLAY;
        end
      end
      S_WAIT: begin
        // A result arriving on the timeout cycle still counts as on time.
        if (bus.sc_out_valid) begin
          w_capture    = 1'b1;
          r_state_next = S_HOLD;
        end else if (w_cnt_inc == CW'(TIMEOUT)) begin
          w_err_cause = ERR_TIMEOUT;
        end
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          w_game_done  = 1'b1;
          r_state_next = S_IDLE;
        end
      end
      default: begin
      end
    endcase
    if (w_err_cause == ERR_NONE && bus.sc_out_valid &&
        r_state != S_WAIT && r_state != S_ERR) begin
      w_err_cause = ERR_OVERLAP;
    end
    if (w_err_cause != ERR_NONE) begin
      r_state_next = S_ERR;
      w_emit       = 1'b0;
      w_capture    = 1'b0;
      w_game_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= r_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_sc_in_valid <= 1'b0;
      r_sc_inning   <= 2'd0;
      r_sc_half     <= 1'b0;
      r_sc_action   <= 3'd0;
      r_res_score_a <= 8'd0;
      r_res_score_b <= 8'd0;
      r_res_result  <= 2'd0;
      r_game_cnt    <= 8'd0;
      r_err         <= 1'b0;
      r_err_code    <= ERR_NONE;
    end else begin
      r_sc_in_valid <= w_emit;
      if (w_emit) begin
        r_sc_inning <= w_inning;
        r_sc_half   <= w_half;
        r_sc_action <= bus.play_action;
      end
      r_cnt <= (r_state == S_WAIT) ? w_cnt_inc : '0;
      if (w_capture) begin
        r_res_score_a <= bus.sc_score_a;
        r_res_score_b <= bus.sc_score_b;
        r_res_result  <= bus.sc_result;
      end
      if (w_game_done) r_game_cnt <= r_game_cnt + 8'd1;
      if (w_err_cause != ERR_NONE && !r_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_cause;
      end
    end
  end

  assign bus.play_ready  = w_play_ready;
  assign bus.sc_in_valid = r_sc_in_valid;
  assign bus.sc_inning   = r_sc_inning;
  assign bus.sc_half     = r_sc_half;
  assign bus.sc_action   = r_sc_action;
  assign bus.res_valid   = (r_state == S_HOLD);
  assign bus.res_score_a = r_res_score_a;
  assign bus.res_score_b = r_res_score_b;
  assign bus.res_result  = r_res_result;
  assign game_cnt        = r_game_cnt;
  assign err             = r_err;
  assign err_code        = r_err_code;

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Controller that sequences one baseball scoring datapath (the scorer block with `in_valid/inning/half/action` in and `out_valid/score_A/score_B/result` out). It accepts a stream of plays from an upstream feed and tracks outs, half and inning itself. It drives the scorer with a gap-free per-game action burst, waits for the scorer's single-cycle result pulse, and holds that result for a downstream consumer. Protocol violations on either side are flagged and latched.

## Interface
- `TIMEOUT`, 100: cycles allowed from end of burst to scorer `out_valid` before error.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `play_valid`  in  1  upstream play present.
- `play_ready`  out  1  sequencer accepts play this cycle.
- `play_action`  in  3  action code, passed unmodified to scorer.
- `play_outs`  in  2  outs recorded by this play (0..2; 3 illegal).
- `play_last`  in  1  final play of the game.
- `sc_in_valid`  out  1  to scorer `in_valid`.
- `sc_inning`  out  2  to scorer `inning` (1..3).
- `sc_half`  out  1  to scorer `half` (0 top, 1 bottom).
- `sc_action`  out  3  to scorer `action`.
- `sc_out_valid`  in  1  scorer `out_valid`.
- `sc_score_a`, `sc_score_b`  in  8 each  scorer scores.
- `sc_result`  in  2  scorer result (0 A wins, 1 B wins, 2 draw).
- `res_valid`  out  1  held result available.
- `res_ready`  in  1  downstream takes result.
- `res_score_a`, `res_score_b`  out  8 each; `res_result`  out  2.
- `game_cnt`  out  8  completed games, wraps 255->0.
- `err`  out  1  sticky error; `err_code`  out  3  first error cause.

## Operation
- States: IDLE, PLAY, WAIT, HOLD, ERR.
- IDLE: `play_ready`=1. The first accepted play sets inning=1, half=0, outs=0 and enters PLAY.
- PLAY: `play_ready`=1. Each accepted play adds `play_outs` to `outs`.
  - On outs==3: outs->0. If half=0, half->1. If half=1, inning+1 and half->0.
  - The fields sent with a play are the pre-update inning/half.
- `play_last` is legal only in inning 3 bottom, or in inning 3 top on the play that makes outs==3. On an accepted last play, go to WAIT.
- Errors (state->ERR, `err`=1, `err_code` latched):
  - 1 STALL: `play_valid`=0 in PLAY.
  - 2 OUTS: outs sum >3, or `play_outs`==3.
  - 3 LAST: `play_last` illegal, or outs==3 in inning 3 bottom without `play_last`.
  - 4 TIMEOUT: counter reaches `TIMEOUT` in WAIT.
  - 5 OVERLAP: `sc_out_valid`=1 while not in WAIT.
- ERR: `play_ready`=0, `sc_in_valid`=0, `res_valid`=0. Leave only by `rst`.
- WAIT: `play_ready`=0. Counter increments each cycle. On `sc_out_valid`=1, capture the three result fields and go to HOLD.
  - If `sc_out_valid` and the TIMEOUT condition occur in the same cycle, capture wins.
- HOLD: `res_valid`=1, fields stable. On `res_ready`=1, `game_cnt`+1 and go to IDLE.
- A second `sc_out_valid` cycle in HOLD also raises OVERLAP (error 5).

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, except `play_ready`=1.
  - `sc_inning`=0, `sc_half`=0, `sc_action`=0.
- Play accepted at edge N: `sc_in_valid`=1 with its fields during cycle N+1. Scorer outputs are registered.
- Back-to-back plays give a continuous `sc_in_valid` burst. `sc_in_valid` falls the cycle after the last play is presented.
- `sc_out_valid` sampled at edge M: `res_valid`=1 from cycle M+1.
- Handshake at edge K: `res_valid`=0 and `play_ready`=1 from cycle K+1. The minimum idle gap in `sc_in_valid` between games is ≥2 cycles.
- TIMEOUT counts cycles starting at the first WAIT cycle. Error is asserted when count==`TIMEOUT` with no `sc_out_valid`.
- `rst` mid-game forces state IDLE and clears counters, error and result registers on the next edge.

## Structure
- Package `game_seq_pkg`:
  - state enum.
  - err code constants (STALL=1, OUTS=2, LAST=3, TIMEOUT=4, OVERLAP=5).
  - `OUTS_PER_HALF`=3, `LAST_INNING`=3, `FIRST_INNING`=1.
  - action code constants 0..7.
- Sub-module `half_inning_tracker`: outs/half/inning counter with load, advance and legality outputs (`half_end`, `outs_overflow`, `last_legal`).
- Top level holds the FSM, output registers, timeout counter, result holding register and `game_cnt`.

## Test plan
- Full game: 18 plays of `play_outs`=1 (three outs per half, inning 1..3 both halves), `play_last` on the 18th; scorer returns 3-2, result 0.
  - Required: 18-cycle contiguous `sc_in_valid` with correct inning/half per play.
  - Required: `res_valid` carrying 3,2,0; `game_cnt`=1 after `res_ready`.
- Early end: top of 3rd ends at outs==3 with `play_last`.
  - Required: no bottom-3 plays emitted; WAIT entered; result held until `res_ready`, with `res_ready` low for 5 cycles first.
- Double play: outs=1, then a play with `play_outs`=2.
  - Required: half advances.
  - Repeat with outs=2 and `play_outs`=2 -> `err_code`=2, `play_ready`=0.
- Stall: `play_valid` low one cycle mid-game -> `err_code`=1, `sc_in_valid`=0 next cycle.
- Timeout: scorer never raises `out_valid` -> `err_code`=4 exactly `TIMEOUT` cycles after WAIT entry. `rst` then returns all outputs to reset values.
- Overlap: `sc_out_valid` pulsed during PLAY -> `err_code`=5.
